// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse stretcher: FSM state encoding,
// miss-counter width and a saturating increment helper.
package pulse_pkg;

  localparam int MISS_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    GUARD = 2'd2
  } state_e;

  function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter with a zero flag; it stops at zero instead of
// wrapping.
module load_down_counter
  import pulse_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches a single-cycle strobe into a level of programmable length,
// followed by a one-cycle guard/done slot; rejected strobes are counted.
module pulse_stretch
  import pulse_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int RETRIG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic [CNT_W-1:0]  len,
  output logic              level_out,
  output logic              busy,
  output logic              done,
  output logic [MISS_W-1:0] miss_cnt
);

  state_e            state_q, state_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              level_q, busy_q, done_q;
  logic              cnt_load, cnt_dec, cnt_zero, miss_inc;

  // len=0 behaves as len=1, so the counter reload is max(len,1)-1.
  function automatic logic [CNT_W-1:0] hold_reload(input logic [CNT_W-1:0] l);
    return (l == '0) ? '0 : l - 1'b1;
  endfunction

  load_down_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (hold_reload(len)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    miss_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pulse_in) begin
          cnt_load = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        // A retrigger beats the counter expiring in the same cycle.
        if (pulse_in && (RETRIG != 0)) begin
          cnt_load = 1'b1;
        end else begin
          miss_inc = pulse_in;
          if (cnt_zero) begin
            state_d = GUARD;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      GUARD: begin
        miss_inc = pulse_in;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    miss_d = miss_inc ? sat_inc(miss_q) : miss_q;
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      miss_q  <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      level_q <= (state_d == HOLD);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == GUARD);
    end
  end

  assign level_out = level_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign miss_cnt  = miss_q;

endmodule
